// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory access sequencer.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_FAULT
    } state_e;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_ILLEGAL  = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/replication and load extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]      st_size_i,
    input  logic [1:0]      st_off_i,
    input  logic [XLEN-1:0] st_data_i,
    output logic [3:0]      mask_o,
    output logic [XLEN-1:0] wdata_o,
    input  logic [1:0]      ld_size_i,
    input  logic [1:0]      ld_off_i,
    input  logic            ld_unsigned_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        mask_o  = 4'b0000;
        wdata_o = st_data_i;
        unique case (st_size_i)
            SZ_B: begin
                mask_o  = 4'b0001 << st_off_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            SZ_H: begin
                mask_o  = 4'b0011 << {st_off_i[1], 1'b0};
                wdata_o = {2{st_data_i[15:0]}};
            end
            SZ_W:    mask_o = 4'b1111;
            default: mask_o = 4'b0000;
        endcase
    end

    // Word accesses are always aligned, so the shift is a no-op for them.
    always_comb begin
        shifted   = rdata_i >> {ld_off_i, 3'b000};
        ld_data_o = shifted;
        unique case (ld_size_i)
            SZ_B: ld_data_o = ld_unsigned_i ? {24'b0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H: ld_data_o = ld_unsigned_i ? {16'b0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer: turns execute-stage intent into a req/gnt/rvalid
// memory transaction, stalling the PC until the access completes or faults.
module dmem_access_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_load,
    input  logic            ex_store,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [1:0]      ex_size,
    input  logic            ex_unsigned,
    input  logic [XLEN-1:0] ex_wdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_mask,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] load_data,
    output logic            load_valid,
    output logic            pc_hold,
    output logic            fault,
    output logic [1:0]      fault_cause
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      size_q;
    logic [1:0]      off_q;
    logic            uns_q;

    logic [3:0]      mask_d;
    logic [XLEN-1:0] wdata_d;
    logic [XLEN-1:0] ld_data_d;
    logic            start_d;
    logic            busy_d;
    logic            resp_d;
    logic            timeout_d;

    lsu_align u_align (
        .st_size_i     (ex_size),
        .st_off_i      (ex_addr[1:0]),
        .st_data_i     (ex_wdata),
        .mask_o        (mask_d),
        .wdata_o       (wdata_d),
        .ld_size_i     (size_q),
        .ld_off_i      (off_q),
        .ld_unsigned_i (uns_q),
        .rdata_i       (dmem_rdata),
        .ld_data_o     (ld_data_d)
    );

    assign start_d   = ex_load | ex_store;
    assign busy_d    = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign resp_d    = ((state_q == ST_REQ) && dmem_gnt && dmem_rvalid)
                    || ((state_q == ST_WAIT) && dmem_rvalid);
    assign timeout_d = busy_d && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign pc_hold   = ((state_q == ST_IDLE) && start_d) || busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            size_q      <= SZ_B;
            off_q       <= 2'b00;
            uns_q       <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            dmem_mask   <= 4'b0000;
            load_data   <= '0;
            load_valid  <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
        end else begin
            load_valid <= 1'b0;
            fault      <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_d) begin
                        if (ex_size == SZ_ILL) begin
                            state_q     <= ST_FAULT;
                            fault       <= 1'b1;
                            fault_cause <= FC_ILLEGAL;
                        end else if (is_misaligned(ex_size, ex_addr[1:0])) begin
                            state_q     <= ST_FAULT;
                            fault       <= 1'b1;
                            fault_cause <= FC_MISALIGN;
                        end else begin
                            state_q    <= ST_REQ;
                            cnt_q      <= '0;
                            size_q     <= ex_size;
                            off_q      <= ex_addr[1:0];
                            uns_q      <= ex_unsigned;
                            dmem_req   <= 1'b1;
                            dmem_we    <= ex_store;
                            dmem_addr  <= {ex_addr[XLEN-1:2], 2'b00};
                            dmem_wdata <= wdata_d;
                            dmem_mask  <= mask_d;
                        end
                    end
                end
                // Timeout wins over a response arriving in the same cycle.
                ST_REQ, ST_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (timeout_d) begin
                        state_q     <= ST_FAULT;
                        dmem_req    <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= FC_TIMEOUT;
                    end else if (resp_d) begin
                        state_q    <= ST_DONE;
                        dmem_req   <= 1'b0;
                        load_valid <= ~dmem_we;
                        if (!dmem_we) begin
                            load_data <= ld_data_d;
                        end
                    end else if ((state_q == ST_REQ) && dmem_gnt) begin
                        state_q  <= ST_WAIT;
                        dmem_req <= 1'b0;
                    end
                end
                ST_DONE:  state_q <= ST_IDLE;
                ST_FAULT: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed table, reset sequences
// and randomized accesses against a behavioural model.
module tb_dmem_access_ctrl;

    localparam int TMO = 16;
    localparam int WIN = 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_load, ex_store, ex_unsigned;
    logic [31:0] ex_addr, ex_wdata;
    logic [1:0]  ex_size;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data;
    logic [3:0]  dmem_mask;
    logic        load_valid, pc_hold, fault;
    logic [1:0]  fault_cause;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .ex_load(ex_load), .ex_store(ex_store), .ex_addr(ex_addr),
        .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_wdata(ex_wdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_mask(dmem_mask), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .load_data(load_data), .load_valid(load_valid), .pc_hold(pc_hold),
        .fault(fault), .fault_cause(fault_cause)
    );

    typedef struct {
        logic        ld;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gd;   // REQ cycles before gnt
        int          rd;   // cycles from gnt to rvalid
    } acc_t;

    typedef struct {
        int          hold, req, lv, flt, done_cyc;
        logic [1:0]  cause;
        logic [31:0] ld, wdata, addr;
        logic [3:0]  mask;
        logic        we;
    } res_t;

    typedef struct {
        acc_t        a;
        logic [3:0]  emask;
        logic [31:0] ewdata, eld;
        logic [1:0]  ecause;
        int          ehold, ereq;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic acc_t mka(input logic ld, input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int gd, input int rd);
        acc_t a;
        a.ld = ld; a.addr = addr; a.size = size; a.uns = uns;
        a.wdata = wdata; a.rdata = rdata; a.gd = gd; a.rd = rd;
        return a;
    endfunction

    function automatic vec_t mkv(input acc_t a, input logic [3:0] emask, input logic [31:0] ewdata,
                                 input logic [31:0] eld, input logic [1:0] ecause,
                                 input int ehold, input int ereq);
        vec_t v;
        v.a = a; v.emask = emask; v.ewdata = ewdata; v.eld = eld;
        v.ecause = ecause; v.ehold = ehold; v.ereq = ereq;
        return v;
    endfunction

    function automatic res_t from_vec(input vec_t v);
        res_t e;
        e.hold = v.ehold; e.req = v.ereq; e.cause = v.ecause;
        e.flt = (v.ecause != 2'b00) ? 1 : 0;
        e.lv  = (v.a.ld && v.ecause == 2'b00) ? 1 : 0;
        e.done_cyc = v.ehold;
        e.ld = v.eld; e.mask = v.emask; e.wdata = v.ewdata;
        e.addr = v.a.addr - (v.a.addr % 4);
        e.we = !v.a.ld;
        return e;
    endfunction

    // Behavioural reference computed from the access rules with plain arithmetic.
    function automatic res_t model(input acc_t a);
        res_t e;
        int off, t, w;
        logic [31:0] sh;
        e = '{default: 0};
        off = int'(a.addr % 4);
        w = 1 << a.size;
        if (a.size == 2'd3 || (off % w) != 0) begin
            e.flt = 1; e.hold = 1; e.done_cyc = 1;
            e.cause = (a.size == 2'd3) ? 2'b11 : 2'b01;
            return e;
        end
        e.addr = a.addr - off;
        e.we = !a.ld;
        e.mask = 4'(((1 << w) - 1) << off);
        if (w == 1)      e.wdata = (a.wdata & 32'hFF)   * 32'h01010101;
        else if (w == 2) e.wdata = (a.wdata & 32'hFFFF) * 32'h00010001;
        else             e.wdata = a.wdata;
        sh = a.rdata >> (8 * off);
        if (w == 4) e.ld = sh;
        else begin
            e.ld = sh % (32'd1 << (8 * w));
            if (!a.uns && e.ld >= (32'd1 << (8 * w - 1))) e.ld = e.ld - (32'd1 << (8 * w));
        end
        t = a.gd + a.rd + 1;
        if (t >= TMO) begin
            e.flt = 1; e.cause = 2'b10; e.hold = 1 + TMO; e.done_cyc = 1 + TMO;
            e.req = (a.gd + 1 < TMO) ? a.gd + 1 : TMO;
        end else begin
            e.hold = 1 + t; e.req = a.gd + 1; e.done_cyc = 1 + t;
            e.lv = a.ld ? 1 : 0;
        end
        return e;
    endfunction

    // Drives one access (cycle 0 = IDLE with ex_* asserted) and plays memory.
    task automatic run_access(input acc_t a, output res_t o);
        int gcyc;
        o = '{default: 0};
        gcyc = -1;
        for (int c = 0; c < WIN; c++) begin
            @(negedge clk);
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = a.rdata;
            ex_load = (c == 0) && a.ld;
            ex_store = (c == 0) && !a.ld;
            ex_addr = a.addr; ex_size = a.size; ex_unsigned = a.uns; ex_wdata = a.wdata;
            #1;
            if (pc_hold) o.hold++;
            if (load_valid) begin o.lv++; o.done_cyc = c; o.ld = load_data; end
            if (fault) begin o.flt++; o.done_cyc = c; o.cause = fault_cause; end
            if (dmem_req) begin
                o.req++;
                o.mask = dmem_mask; o.wdata = dmem_wdata; o.addr = dmem_addr; o.we = dmem_we;
                if (o.req == a.gd + 1) begin dmem_gnt = 1'b1; gcyc = c; end
            end
            if (gcyc >= 0 && c == gcyc + a.rd) dmem_rvalid = 1'b1;
        end
    endtask

    task automatic compare(input string tag, input res_t e, input res_t o);
        chk({tag, ".pc_hold_cycles"}, 32'(o.hold), 32'(e.hold));
        chk({tag, ".req_cycles"}, 32'(o.req), 32'(e.req));
        chk({tag, ".load_valid_pulses"}, 32'(o.lv), 32'(e.lv));
        chk({tag, ".fault_pulses"}, 32'(o.flt), 32'(e.flt));
        if (e.flt != 0) chk({tag, ".fault_cause"}, 32'(o.cause), 32'(e.cause));
        if (e.flt != 0 || e.lv != 0) chk({tag, ".done_cycle"}, 32'(o.done_cyc), 32'(e.done_cyc));
        if (e.lv != 0) chk({tag, ".load_data"}, o.ld, e.ld);
        if (e.req != 0) begin
            chk({tag, ".mask"}, 32'(o.mask), 32'(e.mask));
            chk({tag, ".wdata"}, o.wdata, e.wdata);
            chk({tag, ".addr"}, o.addr, e.addr);
            chk({tag, ".we"}, 32'(o.we), 32'(e.we));
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t o;
        acc_t a;

        rst = 1'b1;
        ex_load = 0; ex_store = 0; ex_addr = 0; ex_size = 0; ex_unsigned = 0; ex_wdata = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.dmem_req", 32'(dmem_req), 32'h0);
        chk("rst.dmem_mask", 32'(dmem_mask), 32'h0);
        chk("rst.dmem_addr", dmem_addr, 32'h0);
        chk("rst.load_data", load_data, 32'h0);
        chk("rst.load_valid", 32'(load_valid), 32'h0);
        chk("rst.fault", 32'(fault), 32'h0);
        chk("rst.fault_cause", 32'(fault_cause), 32'h0);
        chk("rst.pc_hold", 32'(pc_hold), 32'h0);
        rst = 1'b0;

        tbl.push_back(mkv(mka(1, 32'h100, 2'd2, 0, 32'h0, 32'hDEADBEEF, 0, 0),
                          4'hF, 32'h0, 32'hDEADBEEF, 2'b00, 2, 1));
        tbl.push_back(mkv(mka(1, 32'h103, 2'd0, 0, 32'h0, 32'h80112233, 0, 0),
                          4'h8, 32'h0, 32'hFFFFFF80, 2'b00, 2, 1));
        tbl.push_back(mkv(mka(1, 32'h103, 2'd0, 1, 32'h0, 32'h80112233, 0, 0),
                          4'h8, 32'h0, 32'h00000080, 2'b00, 2, 1));
        tbl.push_back(mkv(mka(0, 32'h102, 2'd1, 0, 32'h0000ABCD, 32'h0, 3, 0),
                          4'hC, 32'hABCDABCD, 32'h0, 2'b00, 5, 4));
        tbl.push_back(mkv(mka(1, 32'h101, 2'd2, 0, 32'h0, 32'h0, 0, 0),
                          4'h0, 32'h0, 32'h0, 2'b01, 1, 0));
        tbl.push_back(mkv(mka(1, 32'h200, 2'd3, 0, 32'h0, 32'h0, 0, 0),
                          4'h0, 32'h0, 32'h0, 2'b11, 1, 0));
        tbl.push_back(mkv(mka(1, 32'h104, 2'd2, 0, 32'h0, 32'h55555555, 0, 18),
                          4'hF, 32'h0, 32'h0, 2'b10, 17, 1));
        tbl.push_back(mkv(mka(1, 32'h102, 2'd1, 0, 32'h0, 32'h80011234, 1, 2),
                          4'hC, 32'h0, 32'hFFFF8001, 2'b00, 5, 2));
        tbl.push_back(mkv(mka(0, 32'h101, 2'd0, 0, 32'h000000A5, 32'h0, 0, 1),
                          4'h2, 32'hA5A5A5A5, 32'h0, 2'b00, 3, 1));
        tbl.push_back(mkv(mka(1, 32'h100, 2'd1, 1, 32'h0, 32'h1234F00D, 0, 0),
                          4'h3, 32'h0, 32'h0000F00D, 2'b00, 2, 1));
        tbl.push_back(mkv(mka(1, 32'h10C, 2'd2, 0, 32'h0, 32'h0BADF00D, 14, 0),
                          4'hF, 32'h0, 32'h0BADF00D, 2'b00, 16, 15));
        tbl.push_back(mkv(mka(0, 32'h110, 2'd2, 0, 32'hCAFE0001, 32'h0, 15, 0),
                          4'hF, 32'hCAFE0001, 32'h0, 2'b10, 17, 16));

        foreach (tbl[i]) begin
            run_access(tbl[i].a, o);
            compare($sformatf("vec%0d", i), from_vec(tbl[i]), o);
        end

        // Reset while REQ is outstanding: request must drop at once.
        @(negedge clk);
        ex_load = 1; ex_store = 0; ex_addr = 32'h300; ex_size = 2'd2; ex_unsigned = 0;
        dmem_gnt = 0; dmem_rvalid = 0;
        @(negedge clk);
        ex_load = 0;
        #1 chk("rstreq.req_before", 32'(dmem_req), 32'h1);
        rst = 1'b1;
        #1 chk("rstreq.req_after", 32'(dmem_req), 32'h0);
        chk("rstreq.pc_hold", 32'(pc_hold), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while WAITing for rvalid: state returns to IDLE at once.
        @(negedge clk);
        ex_load = 1; ex_addr = 32'h304;
        @(negedge clk);
        ex_load = 0; dmem_gnt = 1;
        @(negedge clk);
        dmem_gnt = 0;
        #1 chk("rstwait.hold_before", 32'(pc_hold), 32'h1);
        rst = 1'b1;
        #1 chk("rstwait.hold_after", 32'(pc_hold), 32'h0);
        chk("rstwait.addr_after", dmem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_access(tbl[0].a, o);
        compare("post_rst_lw", from_vec(tbl[0]), o);

        for (int n = 0; n < 150; n++) begin
            a.ld    = 1'($urandom_range(0, 1));
            a.addr  = $urandom;
            a.size  = 2'($urandom_range(0, 3));
            a.uns   = 1'($urandom_range(0, 1));
            a.wdata = $urandom;
            a.rdata = $urandom;
            a.gd    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 3));
            a.rd    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 12)) : int'($urandom_range(0, 3));
            run_access(a, o);
            compare($sformatf("rnd%0d", n), model(a), o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
